// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions.
// Holds the divider FSM states, default width and error-quotient constant.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_W = 8;

    localparam logic [DEF_W-1:0] ERR_Q = '1;

endpackage

// File: rtl/radix2_div_step.sv
// One restoring-division iteration: shift in a bit, compare, subtract.
// Ports: pr_i partial remainder, bit_i next dividend bit, divisor_i,
//        pr_o new partial remainder, q_o quotient bit.
module radix2_div_step
    import arith_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] pr_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] pr_o,
    output logic         q_o
);

    logic [W:0] t;

    assign t   = {pr_i, bit_i};
    assign q_o = (t >= {1'b0, divisor_i});

    // When t >= divisor the difference is below divisor, so it fits in
    // W bits and modulo-2^W subtraction of the low bits is exact.
    assign pr_o = q_o ? (t[W-1:0] - divisor_i) : t[W-1:0];

endmodule

// File: rtl/radix2_divider.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, valid/ready on input and output.
// Ports: clk, rst (async high), in_valid/in_ready, dividend, divisor,
//        out_valid/out_ready, quotient, remainder, div_by_zero, overflow.
// Build option: RADIX2_DIVIDER_SIGNED_EN selects two's complement operands.
module radix2_divider
    import arith_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] QERR = {W{ERR_Q[0]}};

    state_t        state_q, state_d;
    logic [W-1:0]  pr_q, pr_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [2*W-1:0] dd_mag;
    logic [W-1:0]   dv_mag;
    logic [W-1:0]   step_pr;
    logic           step_q;
    logic [W-1:0]   qmag;

`ifdef RADIX2_DIVIDER_SIGNED_EN
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
    logic         negq_q, negq_d;
    logic         negr_q, negr_d;
    logic [W-1:0] lo_q, lo_d;

    assign dd_mag = dividend[2*W-1] ? -dividend : dividend;
    assign dv_mag = divisor[W-1] ? -divisor : divisor;
`else
    assign dd_mag = dividend;
    assign dv_mag = divisor;
`endif

    radix2_div_step #(.W(W)) u_step (
        .pr_i      (pr_q),
        .bit_i     (sh_q[W-1]),
        .divisor_i (dvs_q),
        .pr_o      (step_pr),
        .q_o       (step_q)
    );

    // The dividend shift register doubles as the quotient register.
    assign qmag = {sh_q[W-2:0], step_q};

    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
`ifdef RADIX2_DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
        lo_d    = lo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
`ifdef RADIX2_DIVIDER_SIGNED_EN
                    negq_d = dividend[2*W-1] ^ divisor[W-1];
                    negr_d = dividend[2*W-1];
                    lo_d   = dividend[W-1:0];
`endif
                    if (divisor == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        quo_d   = QERR;
                        rem_d   = dividend[W-1:0];
                    end else if (dd_mag[2*W-1:W] >= dv_mag) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        quo_d   = QERR;
                        rem_d   = dividend[W-1:0];
                    end else begin
                        state_d = CALC;
                        pr_d    = dd_mag[2*W-1:W];
                        sh_d    = dd_mag[W-1:0];
                        dvs_d   = dv_mag;
                        cnt_d   = CW'(W);
                    end
                end
            end
            CALC: begin
                pr_d  = step_pr;
                sh_d  = qmag;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
`ifdef RADIX2_DIVIDER_SIGNED_EN
                    // A negative result may reach -2^(W-1); positive
                    // results stop one short of that.
                    if (negq_q ? (qmag > HALF) : (qmag >= HALF)) begin
                        ovf_d = 1'b1;
                        quo_d = QERR;
                        rem_d = lo_q;
                    end else begin
                        quo_d = negq_q ? -qmag : qmag;
                        rem_d = negr_q ? -step_pr : step_pr;
                    end
`else
                    quo_d = qmag;
                    rem_d = step_pr;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pr_q    <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef RADIX2_DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
`ifdef RADIX2_DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            lo_q    <= lo_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
